rr_arbiter8: RTL and testbench

RR_ARBITER8 -- requirements
Module: rr_arbiter8

---
 rtl/arb_pkg.sv | 20 ++
 rtl/prio_enc8.sv | 28 ++
 rtl/rr_arbiter8.sv | 127 ++++++++++++
 tb/tb_rr_arbiter8.sv | 240 ++++++++++++++++++++++++
 4 files changed

// File: rtl/arb_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : arb_pkg
//  Purpose  : Shared constants and state encoding for the 8-way
//             round-robin arbiter.
//  Revision : 1.0 - initial release
// ============================================================================
package arb_pkg;

    localparam int NREQ  = 8;
    localparam int IDX_W = 3;

    // Arbiter is either waiting to arbitrate or holding a grant.
    typedef enum logic [0:0] {
        IDLE  = 1'b0,
        GRANT = 1'b1
    } state_t;

endpackage : arb_pkg
`default_nettype wire

// File: rtl/prio_enc8.sv
`default_nettype none
// ============================================================================
//  Module   : prio_enc8
//  Purpose  : Combinational 8-to-3 priority encoder, lowest set bit wins,
//             with an any-bit-set indication.
//  Revision : 1.0 - initial release
// ============================================================================
module prio_enc8
    import arb_pkg::*;
(
    input  logic [NREQ-1:0]  req,
    output logic [IDX_W-1:0] idx,
    output logic             valid
);

    // Scan from the top down so the lowest set bit is the last one written.
    always_comb begin
        idx   = '0;
        valid = |req;
        for (int i = NREQ - 1; i >= 0; i--) begin
            if (req[i]) begin
                idx = IDX_W'(i);
            end
        end
    end

endmodule : prio_enc8
`default_nettype wire

// File: rtl/rr_arbiter8.sv
`default_nettype none
// ============================================================================
//  Module   : rr_arbiter8
//  Purpose  : 8-requester round-robin arbiter with registered one-hot grant,
//             done/drop release, forced revocation after MAX_HOLD cycles and
//             a one-cycle idle gap between consecutive grants.
//  Revision : 1.0 - initial release
// ============================================================================
module rr_arbiter8
    import arb_pkg::*;
#(
    parameter int MAX_HOLD = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [NREQ-1:0]  req,
    input  logic             done,
    output logic [NREQ-1:0]  gnt,
    output logic [IDX_W-1:0] gnt_idx,
    output logic             gnt_valid,
    output logic             revoked
);

    // Last hold count value at which the grant is still allowed to live.
    localparam logic [7:0] c_hold_last = 8'(MAX_HOLD - 1);

    state_t           r_state,    w_state_nxt;
    logic [IDX_W-1:0] r_ptr,      w_ptr_nxt;
    logic [7:0]       r_hold_cnt, w_hold_nxt;
    logic [NREQ-1:0]  r_gnt,      w_gnt_nxt;
    logic [IDX_W-1:0] r_idx,      w_idx_nxt;
    logic             r_valid,    w_valid_nxt;
    logic             r_revoked,  w_revoked_nxt;

    logic [NREQ-1:0]  w_rot;
    logic [IDX_W-1:0] w_enc_idx;
    logic             w_enc_valid;
    logic [IDX_W-1:0] w_pick;
    logic             w_timeout;
    logic             w_lost;

    // Rotate req right by ptr so the pointer position lands on bit 0.
    always_comb begin
        w_rot = '0;
        for (int i = 0; i < NREQ; i++) begin
            w_rot[i] = req[IDX_W'(i) + r_ptr];
        end
    end

    prio_enc8 u_enc (
        .req   (w_rot),
        .idx   (w_enc_idx),
        .valid (w_enc_valid)
    );

    // Undo the rotation; the 3-bit add wraps modulo 8 naturally.
    assign w_pick    = w_enc_idx + r_ptr;
    assign w_timeout = (r_hold_cnt == c_hold_last);
    assign w_lost    = ~req[r_idx];

    // Next-state and next-output decode for the IDLE/GRANT machine.
    always_comb begin
        w_state_nxt   = r_state;
        w_ptr_nxt     = r_ptr;
        w_hold_nxt    = r_hold_cnt;
        w_gnt_nxt     = r_gnt;
        w_idx_nxt     = r_idx;
        w_valid_nxt   = r_valid;
        w_revoked_nxt = 1'b0;
        case (r_state)
            IDLE: begin
                if (w_enc_valid) begin
                    w_state_nxt = GRANT;
                    w_gnt_nxt   = NREQ'(1) << w_pick;
                    w_idx_nxt   = w_pick;
                    w_valid_nxt = 1'b1;
                    w_hold_nxt  = '0;
                end
            end
            GRANT: begin
                if (done || w_lost || w_timeout) begin
                    w_state_nxt   = IDLE;
                    w_gnt_nxt     = '0;
                    w_idx_nxt     = '0;
                    w_valid_nxt   = 1'b0;
                    w_hold_nxt    = '0;
                    w_ptr_nxt     = r_idx + IDX_W'(1);
                    // Only a pure timeout counts as a revocation.
                    w_revoked_nxt = w_timeout && !done && !w_lost;
                end else begin
                    w_hold_nxt = r_hold_cnt + 8'd1;
                end
            end
            default: begin
                w_state_nxt = IDLE;
            end
        endcase
    end

    // State and output registers; reset clears the grant without a clock.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state    <= IDLE;
            r_ptr      <= '0;
            r_hold_cnt <= '0;
            r_gnt      <= '0;
            r_idx      <= '0;
            r_valid    <= 1'b0;
            r_revoked  <= 1'b0;
        end else begin
            r_state    <= w_state_nxt;
            r_ptr      <= w_ptr_nxt;
            r_hold_cnt <= w_hold_nxt;
            r_gnt      <= w_gnt_nxt;
            r_idx      <= w_idx_nxt;
            r_valid    <= w_valid_nxt;
            r_revoked  <= w_revoked_nxt;
        end
    end

    assign gnt       = r_gnt;
    assign gnt_idx   = r_idx;
    assign gnt_valid = r_valid;
    assign revoked   = r_revoked;

endmodule : rr_arbiter8
`default_nettype wire

// File: tb/tb_rr_arbiter8.sv
`default_nettype none
// ============================================================================
//  Module   : tb_rr_arbiter8
//  Purpose  : Self-checking bench for rr_arbiter8: directed vector table,
//             hand-written multi-cycle sequences and a randomized run
//             against an ownership-level reference model.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_rr_arbiter8;

    localparam int MAX_HOLD = 16;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       done = 1'b0;
    logic [7:0] req = 8'h00;
    logic [7:0] gnt;
    logic [2:0] gnt_idx;
    logic       gnt_valid;
    logic       revoked;

    int checks = 0;
    int errors = 0;

    // Reference model: who owns the resource, for how long, and where the
    // next search starts.
    int   m_owner;
    int   m_ptr;
    int   m_cnt;
    logic m_rev;

    typedef struct {
        logic [7:0] req;
        logic       done;
        logic [7:0] gnt;
        logic [2:0] idx;
        logic       valid;
        logic       rev;
    } vec_t;

    vec_t tbl [15];

    always #5 clk = ~clk;

    rr_arbiter8 #(.MAX_HOLD(MAX_HOLD)) dut (
        .clk       (clk),
        .rst       (rst),
        .req       (req),
        .done      (done),
        .gnt       (gnt),
        .gnt_idx   (gnt_idx),
        .gnt_valid (gnt_valid),
        .revoked   (revoked)
    );

    task automatic model_reset();
        m_owner = -1;
        m_ptr   = 0;
        m_cnt   = 0;
        m_rev   = 1'b0;
    endtask

    task automatic model_edge(input logic [7:0] r, input logic d);
        if (m_owner < 0) begin
            m_rev = 1'b0;
            for (int k = 0; k < 8; k++) begin
                int i;
                i = (m_ptr + k) % 8;
                if (r[i]) begin
                    m_owner = i;
                    m_cnt   = 0;
                    break;
                end
            end
        end else begin
            bit lost;
            bit to;
            lost = !r[m_owner];
            to   = (m_cnt == MAX_HOLD - 1);
            if (d || lost || to) begin
                m_rev   = to && !d && !lost;
                m_ptr   = (m_owner + 1) % 8;
                m_owner = -1;
            end else begin
                m_cnt = m_cnt + 1;
                m_rev = 1'b0;
            end
        end
    endtask

    task automatic check_vals(input string name, input logic [7:0] eg,
                              input logic [2:0] ei, input logic ev,
                              input logic er);
        checks++;
        if (gnt !== eg || gnt_idx !== ei || gnt_valid !== ev || revoked !== er) begin
            errors++;
            $display("FAIL %s: got gnt=%02h idx=%0d valid=%0b revoked=%0b, want gnt=%02h idx=%0d valid=%0b revoked=%0b",
                     name, gnt, gnt_idx, gnt_valid, revoked, eg, ei, ev, er);
        end
    endtask

    task automatic check_model(input string name);
        logic [7:0] eg;
        logic [2:0] ei;
        eg = (m_owner >= 0) ? 8'(1 << m_owner) : 8'h00;
        ei = (m_owner >= 0) ? 3'(m_owner) : 3'd0;
        check_vals(name, eg, ei, m_owner >= 0, m_rev);
    endtask

    task automatic check_int(input string name, input int got, input int want);
        checks++;
        if (got != want) begin
            errors++;
            $display("FAIL %s: got %0d, want %0d", name, got, want);
        end
    endtask

    // Drive inputs while clk is low, let one rising edge happen, advance the
    // model, and return at the following falling edge for sampling.
    task automatic step(input logic [7:0] r, input logic d);
        req  = r;
        done = d;
        @(posedge clk);
        model_edge(r, d);
        @(negedge clk);
    endtask

    task automatic do_reset();
        rst  = 1'b1;
        req  = 8'h00;
        done = 1'b0;
        @(negedge clk);
        model_reset();
        check_vals("reset_state", 8'h00, 3'd0, 1'b0, 1'b0);
        @(negedge clk);
        rst = 1'b0;
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int high;
        int pulses;
        logic [7:0] r;
        logic       d;

        // req, done -> gnt, idx, valid, revoked (starting from reset, ptr=0)
        tbl[0]  = '{8'h01, 1'b0, 8'h01, 3'd0, 1'b1, 1'b0};
        tbl[1]  = '{8'h01, 1'b1, 8'h00, 3'd0, 1'b0, 1'b0};
        tbl[2]  = '{8'h00, 1'b0, 8'h00, 3'd0, 1'b0, 1'b0};
        tbl[3]  = '{8'h00, 1'b1, 8'h00, 3'd0, 1'b0, 1'b0};
        tbl[4]  = '{8'h10, 1'b0, 8'h10, 3'd4, 1'b1, 1'b0};
        tbl[5]  = '{8'h10, 1'b1, 8'h00, 3'd0, 1'b0, 1'b0};
        tbl[6]  = '{8'h11, 1'b0, 8'h01, 3'd0, 1'b1, 1'b0};
        tbl[7]  = '{8'h11, 1'b1, 8'h00, 3'd0, 1'b0, 1'b0};
        tbl[8]  = '{8'h11, 1'b0, 8'h10, 3'd4, 1'b1, 1'b0};
        tbl[9]  = '{8'h11, 1'b0, 8'h10, 3'd4, 1'b1, 1'b0};
        tbl[10] = '{8'h01, 1'b0, 8'h00, 3'd0, 1'b0, 1'b0};
        tbl[11] = '{8'h01, 1'b0, 8'h01, 3'd0, 1'b1, 1'b0};
        tbl[12] = '{8'hFF, 1'b0, 8'h01, 3'd0, 1'b1, 1'b0};
        tbl[13] = '{8'hFF, 1'b1, 8'h00, 3'd0, 1'b0, 1'b0};
        tbl[14] = '{8'hFF, 1'b0, 8'h02, 3'd1, 1'b1, 1'b0};

        do_reset();
        for (int i = 0; i < 15; i++) begin
            step(tbl[i].req, tbl[i].done);
            check_vals($sformatf("vec%0d", i), tbl[i].gnt, tbl[i].idx,
                       tbl[i].valid, tbl[i].rev);
        end

        // Full rotation with every requester active, one gap per release.
        do_reset();
        for (int k = 0; k < 9; k++) begin
            step(8'hFF, 1'b0);
            check_vals($sformatf("rr_grant%0d", k), 8'(1 << (k % 8)), 3'(k % 8), 1'b1, 1'b0);
            step(8'hFF, 1'b1);
            check_vals($sformatf("rr_gap%0d", k), 8'h00, 3'd0, 1'b0, 1'b0);
        end

        // Timeout: requester 2 holds without done.
        do_reset();
        high   = 0;
        pulses = 0;
        step(8'h04, 1'b0);
        for (int c = 0; c < 40; c++) begin
            if (gnt_valid) high++;
            if (revoked) pulses++;
            if (!gnt_valid) break;
            step(8'h04, 1'b0);
        end
        check_int("timeout_hold_cycles", high, MAX_HOLD);
        check_int("timeout_revoked_pulses", pulses, 1);
        step(8'h04, 1'b0);
        check_vals("timeout_regrant", 8'h04, 3'd2, 1'b1, 1'b0);
        step(8'h04, 1'b0);
        check_vals("timeout_revoked_clears", 8'h04, 3'd2, 1'b1, 1'b0);

        // done coinciding with timeout is a normal release.
        do_reset();
        for (int c = 0; c < MAX_HOLD; c++) begin
            step(8'h04, 1'b0);
            check_model("hold_model");
        end
        step(8'h04, 1'b1);
        check_vals("done_with_timeout", 8'h00, 3'd0, 1'b0, 1'b0);

        // Reset in the middle of a grant acts without a clock edge.
        do_reset();
        step(8'h08, 1'b0);
        check_vals("pre_async_rst", 8'h08, 3'd3, 1'b1, 1'b0);
        #2;
        rst = 1'b1;
        #1;
        check_vals("async_rst", 8'h00, 3'd0, 1'b0, 1'b0);
        model_reset();
        @(negedge clk);
        rst = 1'b0;
        step(8'h80, 1'b0);
        check_vals("after_rst_idx7", 8'h80, 3'd7, 1'b1, 1'b0);

        // Randomized run against the reference model.
        do_reset();
        r = 8'($urandom);
        for (int c = 0; c < 600; c++) begin
            if ($urandom_range(0, 7) == 0) r = 8'($urandom);
            d = ($urandom_range(0, 15) == 0);
            step(r, d);
            check_model("random");
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule : tb_rr_arbiter8
`default_nettype wire
